chroma_ref_window: RTL and testbench

- Upstream feeder for the chroma bilinear interpolator in the MC path.
- Accepts a (BLK_W+1)x(BLK_H+1) reference chroma window as a raster pixel stream and stores it locally.
- Then emits, one per cycle, the 2x2 neighbour quad A/B/C/D plus the block's xfrac/yfrac for every output position of a BLK_W x BLK_H chroma block.
- Its outputs drive the interpolator's A, B, C, D, xfrac and yfrac inputs directly.

---
 rtl/chroma_mc_pkg.sv | 18 +
 rtl/chroma_win_mem.sv | 36 +++
 rtl/chroma_ref_window.sv | 171 +++++++++++++++++
 tb/tb_chroma_ref_window.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chroma_mc_pkg.sv
// Shared constants, FSM state encoding and window-index helper for the chroma MC path.
package chroma_mc_pkg;

    localparam int PIX_W_DEF = 8;
    localparam int FRAC_W    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2
    } state_t;

    // Raster position of sample (r,c) inside a window that is blk_w+1 samples wide.
    function automatic int win_idx(input int r, input int c, input int blk_w);
        return r * (blk_w + 1) + c;
    endfunction

endpackage

// File: rtl/chroma_win_mem.sv
// Reference window storage: one write port, four combinational read ports.
// Latency: write visible next cycle, reads same cycle; no backpressure (always writable).
// Contents are not reset; every block rewrites the whole window before it is read.
module chroma_win_mem #(
    parameter int DEPTH = 25,
    parameter int PIX_W = 8,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [PIX_W-1:0] wdat,
    input  logic [IDX_W-1:0] ridx_a,
    input  logic [IDX_W-1:0] ridx_b,
    input  logic [IDX_W-1:0] ridx_c,
    input  logic [IDX_W-1:0] ridx_d,
    output logic [PIX_W-1:0] rdat_a,
    output logic [PIX_W-1:0] rdat_b,
    output logic [PIX_W-1:0] rdat_c,
    output logic [PIX_W-1:0] rdat_d
);

    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdat;
        end
    end

    assign rdat_a = mem[ridx_a];
    assign rdat_b = mem[ridx_b];
    assign rdat_c = mem[ridx_c];
    assign rdat_d = mem[ridx_d];

endmodule

// File: rtl/chroma_ref_window.sv
// Loads a (BLK_W+1)x(BLK_H+1) chroma window, then emits one registered 2x2 quad per handshake.
// Latency: first quad the cycle after the last sample; quads hold while quad_ready is low.
// Optional CHROMA_WIN_STATS_EN adds a 16-bit completed-block counter (blk_count).
module chroma_ref_window
    import chroma_mc_pkg::*;
#(
    parameter int BLK_W = 4,
    parameter int BLK_H = 4,
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [FRAC_W-1:0] xfrac_in,
    input  logic [FRAC_W-1:0] yfrac_in,
    input  logic [PIX_W-1:0]  pix_in,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic              quad_valid,
    input  logic              quad_ready,
    output logic [PIX_W-1:0]  A,
    output logic [PIX_W-1:0]  B,
    output logic [PIX_W-1:0]  C,
    output logic [PIX_W-1:0]  D,
    output logic [FRAC_W-1:0] xfrac,
    output logic [FRAC_W-1:0] yfrac,
    output logic [2:0]        out_x,
    output logic [2:0]        out_y,
    output logic              last,
    output logic              busy
`ifdef CHROMA_WIN_STATS_EN
    ,
    output logic [15:0]       blk_count
`endif
);

    localparam int N     = (BLK_W + 1) * (BLK_H + 1);
    localparam int IDX_W = $clog2(N);
    localparam logic [2:0]       X_MAX   = 3'(BLK_W - 1);
    localparam logic [2:0]       Y_MAX   = 3'(BLK_H - 1);
    localparam logic [IDX_W-1:0] CNT_MAX = IDX_W'(N - 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] cnt;
    logic [2:0]       x, y, nx, ny;
    logic             pix_acc, load_done, hs, quad_upd;
    logic [IDX_W-1:0] ia, ib, ic, id;
    logic [PIX_W-1:0] ra, rb, rc, rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pix_ready  = 1'b0;
        quad_valid = 1'b0;
        busy       = 1'b1;
        last       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                pix_ready = 1'b1;
                if (pix_valid && cnt == CNT_MAX) state_nxt = EMIT;
            end
            EMIT: begin
                quad_valid = 1'b1;
                last       = (x == X_MAX) && (y == Y_MAX);
                if (quad_ready && last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign pix_acc   = pix_valid & pix_ready;
    assign load_done = pix_acc && (cnt == CNT_MAX);
    assign hs        = quad_valid & quad_ready;
    assign quad_upd  = load_done | (hs & ~last);

    // Next output position; wraps to (0,0) after the final quad so read indices stay in range.
    always_comb begin
        nx = 3'd0;
        ny = 3'd0;
        if (hs) begin
            if (x == X_MAX) begin
                ny = (y == Y_MAX) ? 3'd0 : y + 3'd1;
            end else begin
                nx = x + 3'd1;
                ny = y;
            end
        end
    end

    assign ia = IDX_W'(win_idx(int'(ny),     int'(nx),     BLK_W));
    assign ib = IDX_W'(win_idx(int'(ny),     int'(nx) + 1, BLK_W));
    assign ic = IDX_W'(win_idx(int'(ny) + 1, int'(nx),     BLK_W));
    assign id = IDX_W'(win_idx(int'(ny) + 1, int'(nx) + 1, BLK_W));

    chroma_win_mem #(
        .DEPTH (N),
        .PIX_W (PIX_W),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk    (clk),
        .we     (pix_acc),
        .widx   (cnt),
        .wdat   (pix_in),
        .ridx_a (ia),
        .ridx_b (ib),
        .ridx_c (ic),
        .ridx_d (id),
        .rdat_a (ra),
        .rdat_b (rb),
        .rdat_c (rc),
        .rdat_d (rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            x     <= 3'd0;
            y     <= 3'd0;
            A     <= '0;
            B     <= '0;
            C     <= '0;
            D     <= '0;
            xfrac <= '0;
            yfrac <= '0;
        end else begin
            if (state == IDLE && start) begin
                xfrac <= xfrac_in;
                yfrac <= yfrac_in;
                cnt   <= '0;
            end
            if (pix_acc) begin
                cnt <= cnt + 1'b1;
            end
            if (load_done || hs) begin
                x <= nx;
                y <= ny;
            end
            if (quad_upd) begin
                A <= ra;
                B <= rb;
                C <= rc;
                D <= rd;
            end
        end
    end

    assign out_x = x;
    assign out_y = y;

`ifdef CHROMA_WIN_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_count <= 16'd0;
        end else if (hs && last) begin
            blk_count <= blk_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_chroma_ref_window.sv
// Randomized bench for chroma_ref_window against an index-arithmetic quad model.
module tb_chroma_ref_window;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int N  = (W + 1) * (H + 1);
    localparam int Q  = W * H;

    logic       clk = 1'b0;
    logic       rst, start, pix_valid, pix_ready, quad_valid, quad_ready, last, busy;
    logic [2:0] xfrac_in, yfrac_in, xfrac, yfrac, out_x, out_y;
    logic [7:0] pix_in, A, B, C, D;
`ifdef CHROMA_WIN_STATS_EN
    logic [15:0] blk_count;
    int          exp_blk = 0;
`endif

    chroma_ref_window #(.BLK_W(W), .BLK_H(H), .PIX_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .xfrac_in   (xfrac_in),
        .yfrac_in   (yfrac_in),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .quad_valid (quad_valid),
        .quad_ready (quad_ready),
        .A          (A),
        .B          (B),
        .C          (C),
        .D          (D),
        .xfrac      (xfrac),
        .yfrac      (yfrac),
        .out_x      (out_x),
        .out_y      (out_y),
        .last       (last),
`ifdef CHROMA_WIN_STATS_EN
        .blk_count  (blk_count),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    int         k = 0;
    int         vcyc = 0;
    int         ncyc = 0;
    logic [7:0] samples [N];
    logic [2:0] exp_xf, exp_yf;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    // Expected quad k of the current block, derived from the window's raster layout.
    function automatic logic [44:0] model_quad(input int kk);
        int qx, qy, i;
        qx = kk % W;
        qy = kk / W;
        i  = qy * (W + 1) + qx;
        return {samples[i], samples[i+1], samples[i+W+1], samples[i+W+2],
                exp_xf, exp_yf, 3'(qx), 3'(qy), (kk == Q - 1)};
    endfunction

    // Per-cycle compare, then advance to the next falling edge.
    task automatic cyc();
        logic [44:0] got;
        if (quad_valid) begin
            vcyc++;
            got = {A, B, C, D, xfrac, yfrac, out_x, out_y, last};
            if (k >= Q) begin
                check("extra_quad", 64'(k), 64'(Q - 1));
            end else begin
                check($sformatf("quad%0d(A,B,C,D,xf,yf,x,y,last)", k), 64'(got), 64'(model_quad(k)));
            end
            if (quad_ready) k++;
        end
        @(negedge clk);
        ncyc++;
        if (ncyc > 40000) begin
            $display("FAIL cycle_budget: got %0d cycles required under 40000", ncyc);
            $fatal(1);
        end
    endtask

    task automatic start_block(input logic [2:0] xf, input logic [2:0] yf);
        exp_xf   = xf;
        exp_yf   = yf;
        k        = 0;
        vcyc     = 0;
        start    = 1'b1;
        xfrac_in = xf;
        yfrac_in = yf;
        cyc();
        start = 1'b0;
        check("start_enters_load(busy,pix_ready)", {62'd0, busy, pix_ready}, 64'd3);
    endtask

    // mode 0: random pix_valid, 1: toggle 1/0, 2: always valid
    task automatic load(input int mode, input int stop_after, input bit pulse_start);
        int i = 0;
        int n = 0;
        bit ph = 1'b1;
        bit acc;
        while (i < stop_after && n < 1000) begin
            pix_valid = (mode == 1) ? ph : (mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
            ph        = ~ph;
            pix_in    = pix_valid ? samples[i] : 8'($urandom);
            start     = pulse_start && (n == 3);
            xfrac_in  = 3'($urandom);
            yfrac_in  = 3'($urandom);
            if (quad_valid) check("quad_valid_during_load", 64'(quad_valid), 64'd0);
            acc = pix_valid && pix_ready;
            cyc();
            if (acc) i++;
            n++;
        end
        pix_valid = 1'b0;
        start     = 1'b0;
        check("load_accepts", 64'(i), 64'(stop_after));
        if (stop_after == N)
            check("first_quad_latency(quad_valid,pix_ready)", {62'd0, quad_valid, pix_ready}, 64'd2);
    endtask

    // mode 0: ready always, 1: random ready, 2: stall 3 cycles at quad 5
    task automatic emit(input int mode, input bit pulse_start, input bit lit);
        int h = 0;
        int n = 0;
        int stall = 0;
        bit acc;
        while (busy && n < 500) begin
            case (mode)
                0: quad_ready = 1'b1;
                1: quad_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (h == 5 && stall < 3) begin
                        quad_ready = 1'b0;
                        stall++;
                    end else begin
                        quad_ready = 1'b1;
                    end
                end
            endcase
            start    = pulse_start && (n == 2 || (quad_valid && quad_ready && last));
            xfrac_in = 3'($urandom);
            yfrac_in = 3'($urandom);
            if (lit && quad_valid && h == 0)
                check("lit_quad0", 64'({A, B, C, D}), 64'h0001_0506);
            if (lit && quad_valid && h == 15)
                check("lit_quad15(ABCD,last)", 64'({A, B, C, D, 7'd0, last}), 64'h12_13_17_18_01);
            if (mode == 2 && h == 5 && !quad_ready)
                check("lit_stall_hold(ABCD,x,y)", 64'({A, B, C, D, 1'b0, out_x, 1'b0, out_y}),
                      64'h06_07_0B_0C_11);
            acc = quad_valid && quad_ready;
            cyc();
            if (acc) h++;
            n++;
        end
        start = 1'b0;
        check("handshakes_per_block", 64'(h), 64'(Q));
        check("model_quads_consumed", 64'(k), 64'(Q));
        if (mode == 0) check("valid_cycles_at_full_rate", 64'(vcyc), 64'(Q));
        cyc();
        check("idle_after_block(busy,quad_valid,pix_ready)",
              {61'd0, busy, quad_valid, pix_ready}, 64'd0);
`ifdef CHROMA_WIN_STATS_EN
        exp_blk = (exp_blk + 1) % 65536;
        check("blk_count", 64'(blk_count), 64'(exp_blk));
`endif
    endtask

    task automatic fill(input bit ident);
        for (int i = 0; i < N; i++) samples[i] = ident ? 8'(i) : 8'($urandom);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pix_valid = 1'b0; quad_ready = 1'b0;
        xfrac_in = 3'd0; yfrac_in = 3'd0; pix_in = 8'd0;
        exp_xf = 3'd0; exp_yf = 3'd0;
        @(negedge clk);
        cyc();
        cyc();
        check("reset_ctrl(pix_ready,quad_valid,last,busy)",
              {60'd0, pix_ready, quad_valid, last, busy}, 64'd0);
        check("reset_data(ABCD,xf,yf,x,y)",
              64'({A, B, C, D, xfrac, yfrac, out_x, out_y}), 64'd0);
`ifdef CHROMA_WIN_STATS_EN
        check("reset_blk_count", 64'(blk_count), 64'd0);
`endif
        rst = 1'b0;
        cyc();

        fill(1'b1);
        start_block(3'd3, 3'd5);
        load(2, N, 1'b0);
        emit(0, 1'b0, 1'b1);

        fill(1'b1);
        start_block(3'($urandom), 3'($urandom));
        load(0, N, 1'b0);
        emit(2, 1'b0, 1'b0);

        fill(1'b0);
        start_block(3'($urandom), 3'($urandom));
        load(1, N, 1'b0);
        emit(1, 1'b0, 1'b0);

        fill(1'b0);
        start_block(3'($urandom), 3'($urandom));
        load(0, 10, 1'b0);
        rst = 1'b1;
        cyc();
        check("mid_load_reset(pix_ready,busy,quad_valid)",
              {61'd0, pix_ready, busy, quad_valid}, 64'd0);
        rst = 1'b0;
`ifdef CHROMA_WIN_STATS_EN
        exp_blk = 0;
`endif
        fill(1'b0);
        start_block(3'($urandom), 3'($urandom));
        load(0, N, 1'b0);
        emit(1, 1'b0, 1'b0);

        fill(1'b0);
        start_block(3'($urandom), 3'($urandom));
        load(0, N, 1'b1);
        emit(1, 1'b1, 1'b0);

        for (int b = 0; b < 3; b++) begin
            fill(1'b0);
            start_block(3'($urandom), 3'($urandom));
            load(2, N, 1'b0);
            emit(0, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
